// File: rtl/img_op_ctrl_if.sv
// Bus between the image op sequencer and its environment: op handshake, pixel load, SRAM port, conv engine, display strobe.
// o_op_err exists only when CTRL_OP_ERR_EN is defined; names carry the sequencer-side direction.
interface img_op_ctrl_if #(
  parameter int ADDR_BW = 11
);
  logic               i_op_valid;
  logic [3:0]         i_op_mode;
  logic               o_op_ready;
  logic               i_in_valid;
  logic               o_in_ready;
  logic               o_mem_wen;
  logic               o_mem_ren;
  logic [ADDR_BW-1:0] o_mem_addr;
  logic [2:0]         o_org_x;
  logic [2:0]         o_org_y;
  logic [5:0]         o_depth;
  logic               o_conv_start;
  logic               i_conv_done;
  logic               o_out_valid;
`ifdef CTRL_OP_ERR_EN
  logic               o_op_err;

  modport master (
    input  i_op_valid, i_op_mode, i_in_valid, i_conv_done,
    output o_op_ready, o_in_ready, o_mem_wen, o_mem_ren, o_mem_addr,
           o_org_x, o_org_y, o_depth, o_conv_start, o_out_valid, o_op_err
  );

  modport slave (
    output i_op_valid, i_op_mode, i_in_valid, i_conv_done,
    input  o_op_ready, o_in_ready, o_mem_wen, o_mem_ren, o_mem_addr,
           o_org_x, o_org_y, o_depth, o_conv_start, o_out_valid, o_op_err
  );
`else
  modport master (
    input  i_op_valid, i_op_mode, i_in_valid, i_conv_done,
    output o_op_ready, o_in_ready, o_mem_wen, o_mem_ren, o_mem_addr,
           o_org_x, o_org_y, o_depth, o_conv_start, o_out_valid
  );

  modport slave (
    output i_op_valid, i_op_mode, i_in_valid, i_conv_done,
    input  o_op_ready, o_in_ready, o_mem_wen, o_mem_ren, o_mem_addr,
           o_org_x, o_org_y, o_depth, o_conv_start, o_out_valid
  );
`endif
endinterface

// File: rtl/img_op_ctrl.sv
// Image core operation sequencer: op handshake, display origin/depth, SRAM load/display sequencing, conv start/wait.
// Define CTRL_OP_ERR_EN to add the o_op_err pulse for the unused opcodes 9-15.
module img_op_ctrl #(
  parameter int IMG_W      = 8,
  parameter int IMG_MAX_CH = 32,
  parameter int MEM_LAT    = 1,
  parameter int ADDR_BW    = $clog2(IMG_W*IMG_W*IMG_MAX_CH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  img_op_ctrl_if.master bus
);

  localparam int                 CH_BW      = $clog2(IMG_MAX_CH);
  localparam logic [ADDR_BW-1:0] LOAD_LAST  = ADDR_BW'(IMG_W*IMG_W*IMG_MAX_CH - 1);
  localparam logic [ADDR_BW-1:0] DRAIN_LAST = ADDR_BW'(MEM_LAT - 1);
  localparam logic [2:0]         ORG_MAX    = 3'(IMG_W - 2);
  localparam logic [5:0]         MIN_CH     = 6'd8;
  localparam logic [5:0]         MAX_CH     = 6'(IMG_MAX_CH);

  typedef enum logic [2:0] {
    S_INIT,
    S_READY,
    S_WAIT_OP,
    S_LOAD,
    S_EXEC,
    S_CONV,
    S_DISP,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_first;
  logic [3:0]         r_op;
  logic [ADDR_BW-1:0] r_cnt;
  logic [CH_BW-1:0]   r_ch;
  logic [1:0]         r_quad;
  logic [2:0]         r_org_x;
  logic [2:0]         r_org_y;
  logic [5:0]         r_depth;
  logic [MEM_LAT-1:0] r_vpipe;

  logic               w_op_ready;
  logic               w_in_ready;
  logic               w_mem_wen;
  logic               w_mem_ren;
  logic [ADDR_BW-1:0] w_mem_addr;
  logic               w_conv_start;
  logic [2:0]         w_disp_x;
  logic [2:0]         w_disp_y;
  logic [ADDR_BW-1:0] w_disp_addr;
  logic               w_last_ch;

  // Display walks the 2x2 window at the origin per channel: quad bit 0 steps x, bit 1 steps y.
  assign w_disp_x    = r_org_x + {2'b00, r_quad[0]};
  assign w_disp_y    = r_org_y + {2'b00, r_quad[1]};
  assign w_disp_addr = ADDR_BW'({r_ch, w_disp_y, w_disp_x});
  assign w_last_ch   = (6'(r_ch) == (r_depth - 6'd1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_INIT;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_op_ready   = 1'b0;
    w_in_ready   = 1'b0;
    w_mem_wen    = 1'b0;
    w_mem_ren    = 1'b0;
    w_mem_addr   = '0;
    w_conv_start = 1'b0;
    case (r_state)
      S_INIT: w_next = S_READY;
      S_READY: begin
        w_op_ready = 1'b1;
        w_next     = S_WAIT_OP;
      end
      S_WAIT_OP: begin
        if (bus.i_op_valid) begin
          case (bus.i_op_mode)
            4'd0:    w_next = S_LOAD;
            4'd7:    w_next = S_CONV;
            4'd8:    w_next = S_DISP;
            default: w_next = S_EXEC;
          endcase
        end
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        w_mem_addr = r_cnt;
        if (bus.i_in_valid) begin
          w_mem_wen = 1'b1;
          if (r_cnt == LOAD_LAST) begin
            w_next = S_READY;
          end
        end
      end
      S_EXEC: w_next = S_READY;
      // A done arriving together with the start pulse still completes the op.
      S_CONV: begin
        w_conv_start = r_first;
        if (bus.i_conv_done) begin
          w_next = S_READY;
        end
      end
      S_DISP: begin
        w_mem_ren  = 1'b1;
        w_mem_addr = w_disp_addr;
        if ((r_quad == 2'd3) && w_last_ch) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_next = S_READY;
        end
      end
      default: w_next = S_INIT;
    endcase
  end

  // r_cnt is the load address in LOAD and the drain timer in DRAIN; it idles at zero elsewhere.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= 4'd0;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_quad  <= 2'd0;
      r_org_x <= 3'd0;
      r_org_y <= 3'd0;
      r_depth <= MAX_CH;
    end else begin
      if ((r_state == S_WAIT_OP) && bus.i_op_valid) begin
        r_op <= bus.i_op_mode;
      end

      case (r_state)
        S_LOAD: begin
          if (w_mem_wen) begin
            r_cnt <= (r_cnt == LOAD_LAST) ? '0 : r_cnt + ADDR_BW'(1);
          end
        end
        S_DRAIN: r_cnt <= r_cnt + ADDR_BW'(1);
        default: r_cnt <= '0;
      endcase

      if (r_state == S_DISP) begin
        r_quad <= r_quad + 2'd1;
        if (r_quad == 2'd3) begin
          r_ch <= r_ch + CH_BW'(1);
        end
      end else begin
        r_quad <= 2'd0;
        r_ch   <= '0;
      end

      if (r_state == S_EXEC) begin
        case (r_op)
          4'd1: if (r_org_x < ORG_MAX) r_org_x <= r_org_x + 3'd1;
          4'd2: if (r_org_x > 3'd0)    r_org_x <= r_org_x - 3'd1;
          4'd3: if (r_org_y > 3'd0)    r_org_y <= r_org_y - 3'd1;
          4'd4: if (r_org_y < ORG_MAX) r_org_y <= r_org_y + 3'd1;
          4'd5: if (r_depth > MIN_CH)  r_depth <= r_depth >> 1;
          4'd6: if (r_depth < MAX_CH)  r_depth <= r_depth << 1;
          default: ;
        endcase
      end
    end
  end

  // Read strobe delayed by the SRAM latency so o_out_valid lines up with returned data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= w_mem_ren;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
    end
  end

  assign bus.o_op_ready   = w_op_ready;
  assign bus.o_in_ready   = w_in_ready;
  assign bus.o_mem_wen    = w_mem_wen;
  assign bus.o_mem_ren    = w_mem_ren;
  assign bus.o_mem_addr   = w_mem_addr;
  assign bus.o_org_x      = r_org_x;
  assign bus.o_org_y      = r_org_y;
  assign bus.o_depth      = r_depth;
  assign bus.o_conv_start = w_conv_start;
  assign bus.o_out_valid  = r_vpipe[MEM_LAT-1];

`ifdef CTRL_OP_ERR_EN
  assign bus.o_op_err = (r_state == S_EXEC) && (r_op > 4'd8);
`endif

endmodule

// File: tb/tb_img_op_ctrl.sv
// Randomized bench for img_op_ctrl: a behavioural model fills expectation queues, a negedge monitor pops and compares.
// Build with CTRL_OP_ERR_EN defined to also track the opcode error pulse.
module tb_img_op_ctrl;

  localparam int MEM_LAT = 2;
  localparam int ADDR_BW = 11;
  localparam int LOAD_N  = 2048;

  localparam int K_EXEC  = 0;
  localparam int K_DISP  = 1;
  localparam int K_CONV  = 2;
  localparam int K_LOAD  = 3;
  localparam int K_RESET = 4;

  typedef struct {
    int x;
    int y;
    int depth;
    int kind;
  } readyExp_t;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  img_op_ctrl_if #(.ADDR_BW(ADDR_BW)) bus ();

  img_op_ctrl #(
    .IMG_W     (8),
    .IMG_MAX_CH(32),
    .MEM_LAT   (MEM_LAT),
    .ADDR_BW   (ADDR_BW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int relCyc      = 0;
  int lastOv      = -100;
  int lastDone    = -100;
  int modelX      = 0;
  int modelY      = 0;
  int modelDepth  = 32;

  readyExp_t readyQ[$];
  int        wrQ[$];
  int        rdQ[$];
  int        latQ[$];
  int        convQ[$];
  int        errQ[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic finishRun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Monitor: every observable DUT event consumes the matching expectation.
  always @(negedge clk) begin : monitor
    readyExp_t e;
    if (!rstN) begin
      readyQ.delete();
      wrQ.delete();
      rdQ.delete();
      latQ.delete();
      convQ.delete();
      errQ.delete();
    end else begin
      if (bus.i_conv_done) lastDone = cyc;
      if (bus.o_mem_wen) begin
        if (wrQ.size() == 0) checkOutput("wen_spurious", int'(bus.o_mem_wen), 0);
        else checkOutput("wen_addr", int'(bus.o_mem_addr), wrQ.pop_front());
      end
      if (bus.o_mem_ren) begin
        if (rdQ.size() == 0) checkOutput("ren_spurious", int'(bus.o_mem_ren), 0);
        else begin
          checkOutput("ren_addr", int'(bus.o_mem_addr), rdQ.pop_front());
          latQ.push_back(cyc + MEM_LAT);
        end
      end
      if (bus.o_out_valid) begin
        if (latQ.size() == 0) checkOutput("out_valid_spurious", int'(bus.o_out_valid), 0);
        else checkOutput("out_valid_cycle", cyc, latQ.pop_front());
        lastOv = cyc;
      end
      if (bus.o_conv_start) begin
        if (convQ.size() == 0) checkOutput("conv_start_spurious", int'(bus.o_conv_start), 0);
        else checkOutput("conv_start_cycle", cyc, convQ.pop_front());
      end
`ifdef CTRL_OP_ERR_EN
      if (bus.o_op_err) begin
        if (errQ.size() == 0) checkOutput("op_err_spurious", int'(bus.o_op_err), 0);
        else checkOutput("op_err_cycle", cyc, errQ.pop_front());
      end
`endif
      if (bus.o_op_ready) begin
        checkOutput("ready_exclusive", int'(bus.i_op_valid | bus.o_out_valid | bus.o_in_ready), 0);
        if (readyQ.size() == 0) checkOutput("ready_spurious", int'(bus.o_op_ready), 0);
        else begin
          e = readyQ.pop_front();
          checkOutput("org_x", int'(bus.o_org_x), e.x);
          checkOutput("org_y", int'(bus.o_org_y), e.y);
          checkOutput("depth", int'(bus.o_depth), e.depth);
          case (e.kind)
            K_DISP: begin
              checkOutput("ready_after_last_out_valid", cyc - lastOv, 1);
              checkOutput("reads_missing", rdQ.size(), 0);
              checkOutput("out_valid_missing", latQ.size(), 0);
            end
            K_CONV: begin
              checkOutput("ready_after_done", cyc - lastDone, 1);
              checkOutput("conv_start_missing", convQ.size(), 0);
            end
            K_LOAD:  checkOutput("writes_missing", wrQ.size(), 0);
            K_RESET: checkOutput("ready_after_release", cyc - relCyc, 1);
            default: checkOutput("op_err_missing", errQ.size(), 0);
          endcase
        end
      end
    end
  end

  task automatic waitReady();
    int guard = 0;
    while (!bus.o_op_ready && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.o_op_ready) begin
      checkOutput("ready_timeout", int'(bus.o_op_ready), 1);
      finishRun();
    end
  endtask

  task automatic doReset();
    readyExp_t e;
    rstN = 1'b0;
    #1;
    checkOutput("rst_mem_ren", int'(bus.o_mem_ren), 0);
    checkOutput("rst_out_valid", int'(bus.o_out_valid), 0);
    checkOutput("rst_mem_wen", int'(bus.o_mem_wen), 0);
    checkOutput("rst_op_ready", int'(bus.o_op_ready), 0);
    checkOutput("rst_in_ready", int'(bus.o_in_ready), 0);
    checkOutput("rst_conv_start", int'(bus.o_conv_start), 0);
    checkOutput("rst_mem_addr", int'(bus.o_mem_addr), 0);
    checkOutput("rst_org_x", int'(bus.o_org_x), 0);
    checkOutput("rst_org_y", int'(bus.o_org_y), 0);
    checkOutput("rst_depth", int'(bus.o_depth), 32);
    repeat (3) begin
      @(posedge clk); #1;
    end
    modelX     = 0;
    modelY     = 0;
    modelDepth = 32;
    e.x = 0; e.y = 0; e.depth = 32; e.kind = K_RESET;
    readyQ.push_back(e);
    rstN   = 1'b1;
    relCyc = cyc;
  endtask

  task automatic loadPixels();
    int sent = 0;
    int k    = 0;
    while (sent < LOAD_N && k < 4*LOAD_N) begin
      bus.i_in_valid = ((k % 5) != 4) && ($urandom_range(0, 19) != 0);
      if (bus.i_in_valid && bus.o_in_ready) sent++;
      @(posedge clk); #1;
      k++;
    end
    bus.i_in_valid = 1'b0;
    checkOutput("load_accepted", sent, LOAD_N);
  endtask

  task automatic driveConvDone(input int delay);
    for (int i = 0; i < delay; i++) begin
      bus.i_op_valid = (i == 2) && (delay > 4);
      bus.i_op_mode  = 4'd1;
      @(posedge clk); #1;
    end
    bus.i_op_valid  = 1'b0;
    bus.i_conv_done = 1'b1;
    @(posedge clk); #1;
    bus.i_conv_done = 1'b0;
  endtask

  // Model: origin/depth rules and the expected address streams written as plain arithmetic.
  task automatic applyStimulus(input int mode, input int doneDelay);
    readyExp_t e;
    int acceptCyc;
    waitReady();
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    acceptCyc = cyc + 1;
    e.kind = K_EXEC;
    case (mode)
      0: begin
        for (int a = 0; a < LOAD_N; a++) wrQ.push_back(a);
        e.kind = K_LOAD;
      end
      1: if (modelX < 6) modelX++;
      2: if (modelX > 0) modelX--;
      3: if (modelY > 0) modelY--;
      4: if (modelY < 6) modelY++;
      5: if (modelDepth > 8) modelDepth = modelDepth / 2;
      6: if (modelDepth < 32) modelDepth = modelDepth * 2;
      7: begin
        convQ.push_back(acceptCyc);
        e.kind = K_CONV;
      end
      8: begin
        for (int ch = 0; ch < modelDepth; ch++)
          for (int q = 0; q < 4; q++)
            rdQ.push_back(ch*64 + (modelY + q/2)*8 + modelX + q%2);
        e.kind = K_DISP;
      end
      default: begin
`ifdef CTRL_OP_ERR_EN
        errQ.push_back(acceptCyc);
`endif
      end
    endcase
    e.x     = modelX;
    e.y     = modelY;
    e.depth = modelDepth;
    readyQ.push_back(e);
    bus.i_op_valid = 1'b1;
    bus.i_op_mode  = 4'(mode);
    @(posedge clk); #1;
    bus.i_op_valid = 1'b0;
    bus.i_op_mode  = 4'($urandom_range(0, 15));
    if (mode == 0) loadPixels();
    else if (mode == 7) driveConvDone(doneDelay);
  endtask

  task automatic abortDisplay();
    int reads = 0;
    int guard = 0;
    applyStimulus(8, 0);
    while (guard < 300) begin
      if (bus.o_mem_ren) reads++;
      if (reads == 37) break;
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("abort_read_index", reads, 37);
    doReset();
  endtask

  initial begin
    #500000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    finishRun();
  end

  initial begin
    bus.i_op_valid  = 1'b0;
    bus.i_op_mode   = 4'd0;
    bus.i_in_valid  = 1'b0;
    bus.i_conv_done = 1'b0;
    #2;
    $display("[TB] reset and load stream");
    doReset();
    applyStimulus(0, 0);

    $display("[TB] origin clamp and corner display");
    applyStimulus(2, 0);
    applyStimulus(3, 0);
    repeat (7) applyStimulus(1, 0);
    repeat (7) applyStimulus(4, 0);
    applyStimulus(8, 0);

    $display("[TB] depth saturation");
    repeat (3) applyStimulus(5, 0);
    applyStimulus(8, 0);
    repeat (3) applyStimulus(6, 0);

    $display("[TB] display from (1,2) at depth 32");
    repeat (5) applyStimulus(2, 0);
    repeat (4) applyStimulus(3, 0);
    applyStimulus(8, 0);

    $display("[TB] conv handshake and unused opcode");
    applyStimulus(7, 10);
    applyStimulus(7, 0);
    applyStimulus(12, 0);

    $display("[TB] random ops");
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom_range(1, 15), $urandom_range(0, 6));
    end

    $display("[TB] reset abort during display");
    applyStimulus(1, 0);
    applyStimulus(4, 0);
    repeat (2) applyStimulus(6, 0);
    abortDisplay();
    applyStimulus(4, 0);
    applyStimulus(8, 0);
    waitReady();
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("queues_drained",
                readyQ.size() + wrQ.size() + rdQ.size() + latQ.size() + convQ.size() + errQ.size(), 0);
    finishRun();
  end

endmodule
